// File: rtl/pgr_uart_tx_32bit.sv
// Byte-FIFO fronted UART transmitter: 8N1/8N2 frames, one bit per clk_en tick.
// Optional even parity bit after the data bits when UART_TX_PARITY_EN is defined.
module pgr_uart_tx_32bit #(
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          clk_en_i,
  input  logic [7:0]                    tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic                          txd_o,
  output logic                          tx_busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          full, push, pop;

  state_e        state_q, state_d;
  logic          txd_q, txd_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [2:0]    idx_q, idx_d;
  logic          stop_q, stop_d;

  assign full       = (cnt_q == CW'(FIFO_DEPTH));
  // A full FIFO rejects the push even if the same edge pops a byte.
  assign push       = rst_n_i & tx_valid_i & ~full;
  assign tx_ready_o = ~full;
  assign fifo_cnt_o = cnt_q;
  assign txd_o      = txd_q;
  assign tx_busy_o  = (state_q != S_IDLE) || (cnt_q != '0);

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= tx_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      txd_q   <= 1'b1;
      shreg_q <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      txd_q   <= txd_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    txd_d   = txd_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    pop     = 1'b0;
    if (clk_en_i) begin
      case (state_q)
        S_IDLE: begin
          txd_d = 1'b1;
          if (cnt_q != '0) begin
            pop     = 1'b1;
            shreg_d = mem_q[rd_ptr_q];
            txd_d   = 1'b0;
            state_d = S_START;
          end
        end
        S_START: begin
          txd_d   = shreg_q[0];
          idx_d   = 3'd0;
          state_d = S_DATA;
        end
        S_DATA: begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            txd_d   = ^shreg_q;
            state_d = S_PARITY;
`else
            txd_d   = 1'b1;
            stop_d  = 1'b0;
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            txd_d = shreg_q[idx_q + 3'd1];
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          txd_d   = 1'b1;
          stop_d  = 1'b0;
          state_d = S_STOP;
        end
`endif
        S_STOP: begin
          if (stop_q == 1'(STOP_BITS - 1)) begin
            // Last stop tick: chain straight into the next start bit if queued.
            if (cnt_q != '0) begin
              pop     = 1'b1;
              shreg_d = mem_q[rd_ptr_q];
              txd_d   = 1'b0;
              state_d = S_START;
            end else begin
              txd_d   = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
        default: begin
          txd_d   = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end
  end

endmodule
